// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT/MULTU/DIV/DIVU) returning a held HI/LO pair.
// Optional `define MULDIV_ABORT_EN adds an abort input that flushes an operation in flight.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_reg,    state_next;
    logic [CW-1:0]      cnt_reg,      cnt_next;
    logic [2*WIDTH-1:0] acc_reg,      acc_next;
    logic [WIDTH-1:0]   mcand_reg,    mcand_next;
    logic               is_div_reg,   is_div_next;
    logic               sign_a_reg,   sign_a_next;
    logic               sign_b_reg,   sign_b_next;
    logic               dz_pend_reg,  dz_pend_next;
    logic [WIDTH-1:0]   orig_a_reg,   orig_a_next;
    logic [WIDTH-1:0]   hi_reg,       hi_next;
    logic [WIDTH-1:0]   lo_reg,       lo_next;
    logic               divzero_reg,  divzero_next;
`ifdef MULDIV_ABORT_EN
    logic               dz_save_reg,  dz_save_next;
`endif

    // Operand sign/magnitude split; unsigned ops pass the operands through untouched.
    logic               is_signed;
    logic [WIDTH-1:0]   opnd     [2];
    logic [WIDTH-1:0]   opnd_mag [2];
    logic [1:0]         opnd_neg;

    assign is_signed = ~op[0];
    assign opnd[0]   = input1;
    assign opnd[1]   = input2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mag
            assign opnd_neg[gi] = is_signed & opnd[gi][WIDTH-1];
            assign opnd_mag[gi] = opnd_neg[gi] ? (~opnd[gi] + 1'b1) : opnd[gi];
        end
    endgenerate

    // One radix-2 step. acc holds {partial product | multiplier} or {remainder | quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_acc;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_reg};
        step_acc  = '0;
        if (is_div_reg) begin
            if (!div_diff[WIDTH])
                step_acc = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
            else
                step_acc = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        end else begin
            step_acc = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               neg_result;

    always_comb begin
        neg_result = sign_a_reg ^ sign_b_reg;
        prod_fix   = neg_result ? (~acc_reg + 1'b1) : acc_reg;
        quot_fix   = neg_result ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem_fix    = sign_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];
    end

    logic accept;
    logic flush;

    assign accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
`ifdef MULDIV_ABORT_EN
    assign flush  = abort && ((state_reg == S_CALC) || (state_reg == S_FIX));
`else
    assign flush  = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        acc_next     = acc_reg;
        mcand_next   = mcand_reg;
        is_div_next  = is_div_reg;
        sign_a_next  = sign_a_reg;
        sign_b_next  = sign_b_reg;
        dz_pend_next = dz_pend_reg;
        orig_a_next  = orig_a_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        divzero_next = divzero_reg;
`ifdef MULDIV_ABORT_EN
        dz_save_next = dz_save_reg;
`endif
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_next   = S_CALC;
                    cnt_next     = CNT_LAST;
                    is_div_next  = op[1];
                    sign_a_next  = opnd_neg[0];
                    sign_b_next  = opnd_neg[1];
                    orig_a_next  = input1;
                    dz_pend_next = op[1] && (input2 == '0);
                    // Divide: divisor in mcand, dividend shifts out of acc's low half.
                    mcand_next   = op[1] ? opnd_mag[1] : opnd_mag[0];
                    acc_next     = {{WIDTH{1'b0}}, (op[1] ? opnd_mag[0] : opnd_mag[1])};
                    divzero_next = 1'b0;
`ifdef MULDIV_ABORT_EN
                    dz_save_next = divzero_reg;
`endif
                end else if (state_reg == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_CALC: begin
                acc_next = step_acc;
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == '0)
                    state_next = S_FIX;
            end
            S_FIX: begin
                state_next = S_DONE;
                if (!is_div_reg) begin
                    {hi_next, lo_next} = prod_fix;
                end else if (dz_pend_reg) begin
                    hi_next      = orig_a_reg;
                    lo_next      = '1;
                    divzero_next = 1'b1;
                end else begin
                    hi_next = rem_fix;
                    lo_next = quot_fix;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A flushed operation leaves the previous result (including divzero) visible.
        if (flush) begin
            state_next   = S_IDLE;
            hi_next      = hi_reg;
            lo_next      = lo_reg;
`ifdef MULDIV_ABORT_EN
            divzero_next = dz_save_reg;
`endif
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            dz_pend_reg <= 1'b0;
            orig_a_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            divzero_reg <= 1'b0;
`ifdef MULDIV_ABORT_EN
            dz_save_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            acc_reg     <= acc_next;
            mcand_reg   <= mcand_next;
            is_div_reg  <= is_div_next;
            sign_a_reg  <= sign_a_next;
            sign_b_reg  <= sign_b_next;
            dz_pend_reg <= dz_pend_next;
            orig_a_reg  <= orig_a_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            divzero_reg <= divzero_next;
`ifdef MULDIV_ABORT_EN
            dz_save_reg <= dz_save_next;
`endif
        end
    end

    assign busy    = (state_reg == S_CALC) || (state_reg == S_FIX);
    assign done    = (state_reg == S_DONE);
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign divzero = divzero_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes model results, a done-driven monitor pops and compares.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  input1 = '0;
    logic [W-1:0]  input2 = '0;
    logic          busy, done, divzero;
    logic [W-1:0]  hi, lo;
`ifdef MULDIV_ABORT_EN
    logic          abort = 1'b0;
`endif

    int tests = 0;
    int failed = 0;
    int done_cnt = 0;

    logic [2*W:0] exp_q [$];
    string        name_q [$];

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op),
        .input1(input1), .input2(input2),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .hi(hi), .lo(lo), .divzero(divzero)
    );

    // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero like DIV.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            MULT:  begin p = sa * sb; return {1'b0, p}; end
            MULTU: begin p = ua * ub; return {1'b0, p}; end
            DIV: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                p = ua / ub;
                q = longint'(ua % ub);
                return {1'b0, q[31:0], p[31:0]};
            end
        endcase
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge CLK) begin
        logic [2*W:0] e;
        string n;
        if (nRST && done) begin
            done_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_done: got hi=%h lo=%h dz=%b, required no done pulse", hi, lo, divzero);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if ({divzero, hi, lo} !== e) begin
                    failed++;
                    $display("FAIL %s: got hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                             n, hi, lo, divzero, e[2*W-1:W], e[W-1:0], e[2*W]);
                end else begin
                    $display("[TB] %s hi=%h lo=%h dz=%b ok", n, hi, lo, divzero);
                end
            end
        end
    end

    task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        op     = o;
        input1 = a;
        input2 = b;
        exp_q.push_back(model(o, a, b));
        name_q.push_back($sformatf("op%0d_%h_%h", o, a, b));
    endtask

    // Called on the negedge where start was raised; returns on the negedge showing done.
    task automatic track(input int inject_at);
        int cyc, bad;
        bit seen;
        cyc = 0; bad = 0; seen = 0;
        while (!seen && cyc < 100) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            start = 1'b0;
            if (inject_at != 0 && cyc == inject_at) begin
                start  = 1'b1;
                op     = 2'($urandom);
                input1 = $urandom;
                input2 = $urandom;
            end
            if (done) begin
                seen = 1;
                if (busy) bad++;
            end else if (!busy) begin
                bad++;
            end
            if (cyc == 1 && divzero) bad++;
        end
        tests++;
        if (!seen) begin
            failed++;
            $display("FAIL timeout: got no done after %0d cycles, required done at 34", cyc);
        end else if (cyc != 34) begin
            failed++;
            $display("FAIL latency: got %0d cycles, required 34", cyc);
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL busy_window: got %0d busy/divzero violations, required 0", bad);
        end
    endtask

    task automatic run_one(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
        @(negedge CLK);
        launch(o, a, b);
        track(inject_at);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        // Reset state.
        #2;
        tests++;
        if ({hi, lo, busy, done, divzero} !== '0) begin
            failed++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                     hi, lo, busy, done, divzero);
        end
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        // Directed cases.
        run_one(MULT,  32'hFFFF_FFFD, 32'd5, 0);
        run_one(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_one(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_one(DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_one(DIVU,  32'd100, 32'd7, 0);
        run_one(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_one(DIVU,  32'd100, 32'd0, 0);
        run_one(DIV,   32'hFFFF_FF9C, 32'd0, 0);
        run_one(MULT,  32'h8000_0000, 32'h8000_0000, 0);
        // Start mid-operation is ignored.
        run_one(MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        // Back-to-back: next start issued on the done cycle.
        @(negedge CLK);
        launch(DIVU, 32'd100, 32'd0);
        track(0);
        launch(DIV, 32'h7FFF_FFFF, 32'hFFFF_FFF0);
        track(0);
        launch(MULT, 32'h0001_0000, 32'hFFFF_0000);
        track(0);

        // Randomized ops.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [W-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_one(o, a, b, (i % 5 == 0) ? $urandom_range(2, 30) : 0);
        end

        // Asynchronous reset mid-CALC discards the operation.
        @(negedge CLK);
        launch(MULTU, 32'hDEAD_BEEF, 32'h0000_1234);
        @(negedge CLK);
        start = 1'b0;
        repeat (8) @(negedge CLK);
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        tests++;
        if ({hi, lo, busy, done, divzero} !== '0) begin
            failed++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b done=%b dz=%b, required all zero",
                     hi, lo, busy, done, divzero);
        end
        exp_q.delete();
        name_q.delete();
        dc = done_cnt;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (40) @(negedge CLK);
        tests++;
        if (done_cnt != dc || busy) begin
            failed++;
            $display("FAIL reset_no_done: got %0d done pulses busy=%b, required 0 and idle", done_cnt - dc, busy);
        end
        run_one(MULT, 32'd6, 32'd7, 0);

`ifdef MULDIV_ABORT_EN
        // Abort mid-CALC: no done and the previous result stays visible.
        @(negedge CLK);
        launch(DIVU, 32'd1000, 32'd3);
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
        dc = done_cnt;
        repeat (40) @(negedge CLK);
        tests++;
        if (done_cnt != dc || busy || hi !== 32'd0 || lo !== 32'd42) begin
            failed++;
            $display("FAIL abort: got dones=%0d busy=%b hi=%h lo=%h, required 0 idle hi=0 lo=2a",
                     done_cnt - dc, busy, hi, lo);
        end
`endif

        repeat (2) @(negedge CLK);
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
